// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between two valid/ready requesters.
// Each op is registered, run through the ALU for one cycle, and returned with its requester id.
module alu_share_arbiter #(
    parameter int unsigned bit_size = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [3:0]          req0_op_i,
    input  logic [bit_size-1:0] req0_src1_i,
    input  logic [bit_size-1:0] req0_src2_i,
    input  logic [4:0]          req0_shamt_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [3:0]          req1_op_i,
    input  logic [bit_size-1:0] req1_src1_i,
    input  logic [bit_size-1:0] req1_src2_i,
    input  logic [4:0]          req1_shamt_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic                resp_id_o,
    output logic [bit_size-1:0] resp_result_o,
    output logic                resp_zero_o,
    output logic [CNT_W-1:0]    ops_done_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic [3:0]          op_q, op_d;
    logic [bit_size-1:0] src1_q, src1_d;
    logic [bit_size-1:0] src2_q, src2_d;
    logic [4:0]          shamt_q, shamt_d;
    logic                id_q, id_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_id_q, resp_id_d;
    logic [bit_size-1:0] resp_result_q, resp_result_d;
    logic                resp_zero_q, resp_zero_d;
    logic [CNT_W-1:0]    ops_done_q, ops_done_d;

    logic                grant_vld_c;
    logic                grant_c;
    logic [bit_size-1:0] alu_result_c;
    logic                alu_zero_c;

    // Round-robin pick: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant_vld_c = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_c = ~rr_last_q;
        end else begin
            grant_c = req1_valid_i;
        end
    end

    assign req0_ready_o = (state_q == ST_IDLE) && grant_vld_c && !grant_c;
    assign req1_ready_o = (state_q == ST_IDLE) && grant_vld_c && grant_c;

    // Shared ALU, fed only from the latched operands.
    always_comb begin
        alu_result_c = '0;
        unique case (op_q)
            4'b0001: alu_result_c = src1_q + src2_q;
            4'b0010: alu_result_c = src1_q - src2_q;
            4'b0011: alu_result_c = src1_q & src2_q;
            4'b0100: alu_result_c = src1_q | src2_q;
            4'b0101: alu_result_c = src1_q ^ src2_q;
            4'b0110: alu_result_c = ~(src1_q | src2_q);
            4'b0111: alu_result_c = bit_size'(src1_q < src2_q);
            4'b1000: alu_result_c = src2_q << shamt_q;
            4'b1001: alu_result_c = src2_q >> shamt_q;
            default: alu_result_c = '0;
        endcase
        alu_zero_c = (alu_result_c == '0);
    end

    // Next-state and datapath updates for IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        op_d          = op_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        shamt_d       = shamt_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        ops_done_d    = ops_done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld_c) begin
                    rr_last_d = grant_c;
                    id_d      = grant_c;
                    op_d      = grant_c ? req1_op_i    : req0_op_i;
                    src1_d    = grant_c ? req1_src1_i  : req0_src1_i;
                    src2_d    = grant_c ? req1_src2_i  : req0_src2_i;
                    shamt_d   = grant_c ? req1_shamt_i : req0_shamt_i;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_result_d = alu_result_c;
                resp_zero_d   = alu_zero_c;
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    ops_done_d   = ops_done_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; last winner resets to 1 so req0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_last_q     <= 1'b1;
            op_q          <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            shamt_q       <= '0;
            id_q          <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            ops_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            op_q          <= op_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            shamt_q       <= shamt_d;
            id_q          <= id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            ops_done_q    <= ops_done_d;
        end
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_id_o     = resp_id_q;
    assign resp_result_o = resp_result_q;
    assign resp_zero_o   = resp_zero_q;
    assign ops_done_o    = ops_done_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table plus tie, stall, reset and wrap sequences.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        resp_valid, resp_ready, resp_id, resp_zero, busy;
    logic [31:0] resp_result;
    logic [15:0] ops_done;

    logic        w_req0_ready, w_req1_ready, w_resp_valid, w_resp_id, w_resp_zero, w_busy;
    logic [31:0] w_resp_result;
    logic [1:0]  w_ops_done;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    alu_share_arbiter #(.bit_size(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
        .req0_src1_i(req0_src1), .req0_src2_i(req0_src2), .req0_shamt_i(req0_shamt),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
        .req1_src1_i(req1_src1), .req1_src2_i(req1_src2), .req1_shamt_i(req1_shamt),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
        .resp_result_o(resp_result), .resp_zero_o(resp_zero),
        .ops_done_o(ops_done), .busy_o(busy)
    );

    // Narrow-counter instance driven by the same stimulus, for the wrap check.
    alu_share_arbiter #(.bit_size(32), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(w_req0_ready), .req0_op_i(req0_op),
        .req0_src1_i(req0_src1), .req0_src2_i(req0_src2), .req0_shamt_i(req0_shamt),
        .req1_valid_i(req1_valid), .req1_ready_o(w_req1_ready), .req1_op_i(req1_op),
        .req1_src1_i(req1_src1), .req1_src2_i(req1_src2), .req1_shamt_i(req1_shamt),
        .resp_valid_o(w_resp_valid), .resp_ready_i(resp_ready), .resp_id_o(w_resp_id),
        .resp_result_o(w_resp_result), .resp_zero_o(w_resp_zero),
        .ops_done_o(w_ops_done), .busy_o(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic r, input logic [3:0] op, input logic [31:0] s1,
                             input logic [31:0] s2, input logic [4:0] sh);
        if (r) begin
            req1_valid = 1'b1; req1_op = op; req1_src1 = s1; req1_src2 = s2; req1_shamt = sh;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_src1 = s1; req0_src2 = s2; req0_shamt = sh;
        end
    endtask

    task automatic run_op(input logic r, input logic [3:0] op, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [4:0] sh,
                          input logic [31:0] res, input logic z);
        @(negedge clk);
        drive_req(r, op, s1, s2, sh);
        #1;
        check("grant_ready", {req1_ready, req0_ready}, r ? 64'd2 : 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("exec_busy", busy, 1);
        check("exec_resp_valid", resp_valid, 0);
        @(negedge clk);
        #1;
        check("resp_valid", resp_valid, 1);
        check("resp_result", resp_result, res);
        check("resp_zero", resp_zero, z);
        check("resp_id", resp_id, r);
        resp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        #1;
        resp_ready = 1'b0;
        check("post_resp_valid", resp_valid, 0);
        check("ops_done", ops_done, 64'(exp_cnt));
        check("ops_done_wrap", w_ops_done, 64'(exp_cnt % 4));
    endtask

    initial begin
        // op, operands, and hand-computed results
        vecs[0]  = '{1'b0, 4'b0001, 32'd5,          32'd7,          5'd0,  32'd12,         1'b0};
        vecs[1]  = '{1'b1, 4'b0010, 32'd9,          32'd9,          5'd0,  32'd0,          1'b1};
        vecs[2]  = '{1'b0, 4'b0100, 32'hF0,         32'h0F,         5'd0,  32'hFF,         1'b0};
        vecs[3]  = '{1'b1, 4'b1000, 32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0};
        vecs[4]  = '{1'b1, 4'b1001, 32'd0,          32'h8000_0000,  5'd31, 32'd1,          1'b0};
        vecs[5]  = '{1'b0, 4'b0011, 32'hFF00,       32'h0FF0,       5'd0,  32'h0F00,       1'b0};
        vecs[6]  = '{1'b1, 4'b0101, 32'd5,          32'd3,          5'd0,  32'd6,          1'b0};
        vecs[7]  = '{1'b0, 4'b0110, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0};
        vecs[8]  = '{1'b0, 4'b0111, 32'd1,          32'hFFFF_FFFF,  5'd0,  32'd1,          1'b0};
        vecs[9]  = '{1'b1, 4'b0111, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1};
        vecs[10] = '{1'b0, 4'b0001, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1};
        vecs[11] = '{1'b1, 4'b0010, 32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0};
        vecs[12] = '{1'b0, 4'b1010, 32'd3,          32'd3,          5'd0,  32'd0,          1'b1};
        vecs[13] = '{1'b1, 4'b1011, 32'd3,          32'd4,          5'd0,  32'd0,          1'b1};
        vecs[14] = '{1'b0, 4'b0000, 32'd7,          32'd8,          5'd3,  32'd0,          1'b1};
        vecs[15] = '{1'b1, 4'b1111, 32'd5,          32'd5,          5'd1,  32'd0,          1'b1};

        rst_n = 1'b0;
        resp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_src1 = '0; req0_src2 = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0; req1_shamt = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_result", resp_result, 0);
        check("rst_zero_id", {resp_zero, resp_id}, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add right out of reset, then the whole vector table.
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].r, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].sh,
                   vecs[i].res, vecs[i].z);
        end

        // Reset again so the tie sequence starts from the reset tie-breaker.
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters valid back to back: grants alternate 0,1,0,1.
        begin
            int got;
            logic tie_id;
            got = 0;
            tie_id = 1'b0;
            @(negedge clk);
            drive_req(1'b0, 4'b0010, 32'd9, 32'd9, 5'd0);
            drive_req(1'b1, 4'b0100, 32'hF0, 32'h0F, 5'd0);
            resp_ready = 1'b1;
            #1;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                if (busy) begin
                    check("busy_ready", {req1_ready, req0_ready}, 0);
                end else begin
                    check("tie_grant", {req1_ready, req0_ready}, tie_id ? 64'd2 : 64'd1);
                end
                if (resp_valid) begin
                    check("tie_id", resp_id, tie_id);
                    check("tie_result", resp_result, tie_id ? 64'hFF : 64'h0);
                    check("tie_zero", resp_zero, tie_id ? 64'd0 : 64'd1);
                    got++;
                    exp_cnt++;
                    tie_id = ~tie_id;
                end
                @(negedge clk);
                #1;
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            resp_ready = 1'b0;
            check("tie_count", 64'(got), 4);
            check("tie_ops_done", ops_done, 64'(exp_cnt));
            check("tie_ops_done_wrap", w_ops_done, 64'(exp_cnt % 4));
        end

        // Consumer stalls for 5 cycles: response held, no new grant until handshake.
        @(negedge clk);
        drive_req(1'b1, 4'b0101, 32'h0F0F, 32'h00FF, 5'd0);
        #1;
        check("stall_grant", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        drive_req(1'b0, 4'b0001, 32'd1, 32'd2, 5'd0);
        #1;
        check("stall_exec_ready", {req1_ready, req0_ready}, 0);
        @(negedge clk);
        #1;
        check("stall_rv", resp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("stall_hold_valid", resp_valid, 1);
            check("stall_hold_result", resp_result, 32'h0FF0);
            check("stall_hold_id_zero", {resp_id, resp_zero}, 2'b10);
            check("stall_hold_ready", {req1_ready, req0_ready}, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        resp_ready = 1'b0;
        #1;
        check("stall_released", resp_valid, 0);
        check("stall_next_grant", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        begin
            int waited;
            waited = 0;
            #1;
            while (!resp_valid && waited < 10) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("stall_next_resp_seen", resp_valid, 1);
            check("stall_next_result", resp_result, 3);
            check("stall_next_id", resp_id, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        resp_ready = 1'b0;
        #1;
        check("stall_ops_done", ops_done, 64'(exp_cnt));

        // Reset during EXEC: op discarded; tie-breaker returns to req0.
        @(negedge clk);
        drive_req(1'b0, 4'b0001, 32'd8, 32'd8, 5'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ops_done", ops_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("midrst_no_resp", resp_valid, 0);
        check("midrst_no_count", ops_done, 0);
        @(negedge clk);
        drive_req(1'b1, 4'b0010, 32'd5, 32'd1, 5'd0);
        req1_valid = 1'b0;
        run_op(1'b0, 4'b0001, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);

        // A tie right after the mid-op reset must go to req0 again.
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_req(1'b0, 4'b0001, 32'd1, 32'd1, 5'd0);
        drive_req(1'b1, 4'b0010, 32'd5, 32'd1, 5'd0);
        #1;
        check("rst_tie_grant", {req1_ready, req0_ready}, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rst_tie_result", resp_result, 2);
        check("rst_tie_id", resp_id, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("rst_tie_ops_done", ops_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
